// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and FSM encoding for the pipeline controller.
package pipe_ctrl_pkg;

   // CP0 Cause.ExcCode values used by the pipeline
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'h0000_4180;

   typedef enum logic {
      RUN    = 1'b0,
      REFILL = 1'b1
   } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_md_busy_timer.sv
// md_busy_timer: HI/LO multiply/divide busy counter. Loads on issue, counts
// down to zero, busy while nonzero.
module md_busy_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic is_div,
   output logic busy
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW         = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] count;

   // load on issue (reloads even if already busy), else saturating decrement
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (count != '0) begin
         count <= count - CW'(1);
      end
   end

   assign busy = (count != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect controller for the five-stage pipeline.
// Handles exceptions, interrupts and eret at M, plus the mult/div busy stall.
// Optional performance counters: define PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES   = 5,
   parameter int unsigned DIV_CYCLES    = 10,
   parameter logic [31:0] EXC_ENTRY     = EXC_ENTRY_DEFAULT,
   parameter int unsigned REFILL_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_hazD,
   input  logic        md_useD,
   input  logic        md_startE,
   input  logic        md_is_divE,
   input  logic        validM,
   input  logic [31:0] pcM,
   input  logic        bdM,
   input  logic [4:0]  exc_codeM,
   input  logic        eretM,
   input  logic        int_req,
   input  logic [31:0] epc_in,
   output logic        stallF,
   output logic        stallD,
   output logic        flushD,
   output logic        flushE,
   output logic        flushM,
   output logic        md_busy,
   output logic        exc_take,
   output logic [4:0]  exc_code_out,
   output logic [31:0] epc_out,
   output logic        redirect,
   output logic [31:0] redirect_pc
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [15:0] exc_cnt
`endif
);

   localparam int unsigned RW = (REFILL_CYCLES < 2) ? 1 : $clog2(REFILL_CYCLES + 1);

   ctrl_state_t   state;
   logic [RW-1:0] refill_cnt;
   logic          take_int;
   logic          take_exc;
   logic          eret_take;
   logic          stall;
   logic          md_load;

   md_busy_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (md_load),
      .is_div (md_is_divE),
      .busy   (md_busy)
   );

   // exception/eret/stall decode; everything is gated by reset so that
   // outputs read as idle while reset is held, whatever the inputs do
   always_comb begin
      take_int     = reset & int_req & validM & (state == RUN);
      take_exc     = reset & validM & (exc_codeM != '0);
      exc_take     = take_int | take_exc;
      eret_take    = reset & eretM & validM & ~exc_take;
      redirect     = exc_take | eret_take;
      redirect_pc  = eret_take ? epc_in : EXC_ENTRY;
      exc_code_out = take_int ? EXC_INT : (reset ? exc_codeM : '0);
      epc_out      = reset ? ((bdM ? (pcM - 32'd4) : pcM) & ~32'h3) : '0;
      stall        = reset & (stall_hazD | (md_useD & (md_busy | md_startE)));
      stallF       = stall & ~redirect;
      stallD       = stall & ~redirect;
      flushD       = redirect;
      flushE       = redirect | stall;
      flushM       = redirect;
      md_load      = md_startE & ~exc_take & ~eretM;
   end

   // RUN/REFILL: mask interrupts for REFILL_CYCLES after every redirect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         refill_cnt <= '0;
      end else if (redirect) begin
         state      <= REFILL;
         refill_cnt <= RW'(REFILL_CYCLES);
      end else if (state == REFILL) begin
         refill_cnt <= (refill_cnt != '0) ? refill_cnt - RW'(1) : '0;
         if (refill_cnt <= RW'(1)) begin
            state <= RUN;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   // wrap-around counters of effective stall cycles and taken exceptions
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         exc_cnt   <= '0;
      end else begin
         if (stall && !redirect) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (exc_take) begin
            exc_cnt <= exc_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush/redirect controller for the five-stage MIPS pipeline.
- Drives the stall and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Owns the HI/LO multiply/divide busy timer, and takes exceptions, interrupts and eret at the M stage.
- Emits the PC redirect and the EPC/ExcCode values that CP0 records.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu issues in E.
- DIV_CYCLES, 10, busy cycles after div/divu issues in E.
- EXC_ENTRY, 32'h0000_4180, exception handler address.
- REFILL_CYCLES, 3, interrupt-mask window after any redirect.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall_hazD  in  1  operand-forwarding hazard from the D-stage decoder.
- md_useD  in  1  D-stage instruction reads or writes HI/LO, or is mult/div.
- md_startE  in  1  mult/div valid in E this cycle.
- md_is_divE  in  1  1 = div/divu, 0 = mult/multu.
- validM  in  1  M stage holds a real instruction, not a bubble.
- pcM  in  32  PC of the M-stage instruction.
- bdM  in  1  M-stage instruction is in a delay slot.
- exc_codeM  in  5  ExcCode[6:2] piped to M; 0 = none.
- eretM  in  1  eret in M.
- int_req  in  1  CP0 interrupt pending and enabled.
- epc_in  in  32  current CP0 EPC.
- stallF, stallD  out  1  hold PC and IF/ID.
- flushD, flushE, flushM  out  1  clear IF/ID, ID/EX, EX/MEM.
- md_busy  out  1  timer nonzero.
- exc_take  out  1  CP0 writes EPC, Cause and EXL this cycle.
- exc_code_out  out  5  code written to Cause.
- epc_out  out  32  EPC value to record.
- redirect  out  1  PC mux selects redirect_pc.
- redirect_pc  out  32  next-PC target.

Behaviour:
- Reset (reset=0, asynchronous):
  - md counter = 0; FSM = RUN; refill counter = 0.
  - All outputs are 0 except redirect_pc, which is EXC_ENTRY.
- MD timer:
  - md_startE && !exc_take && !eretM loads MULT_CYCLES or DIV_CYCLES on the next edge.
  - Otherwise the counter decrements when nonzero; it saturates at 0.
  - md_busy = (count != 0).
  - A start while busy cannot occur because of the stall below; if one does, reload anyway.
  - An exception does not stop an in-progress count, because the HI/LO write is committed.
- Stall (combinational):
  - stall = stall_hazD | (md_useD & (md_busy | md_startE)).
  - stall=1 gives stallF=stallD=1 and flushE=1, inserting a bubble into E.
- Exception, combinational in the same cycle:
  - take_int = int_req & validM & (state==RUN).
  - take_exc = validM & (exc_codeM != 0).
  - exc_take = take_int | take_exc.
  - exc_code_out = take_int ? 0 : exc_codeM. The interrupt has priority.
  - epc_out = bdM ? pcM-4 : pcM, with bits [1:0] forced to 0.
  - redirect=1, redirect_pc=EXC_ENTRY.
  - flushD=flushE=flushM=1; stallF=stallD=0. This overrides stall.
- Eret:
  - eretM & validM & !exc_take gives redirect=1, redirect_pc=epc_in, flushD/E/M=1, stalls=0.
  - exc_take wins over eretM.
- FSM RUN/REFILL:
  - Any redirect moves the FSM to REFILL and loads the refill counter with REFILL_CYCLES.
  - In REFILL, int_req is ignored while synchronous exceptions are still taken.
  - The counter decrements each cycle; the FSM returns to RUN after the cycle in which it reaches 1.
  - A redirect during REFILL reloads the counter.
- Priority: exc_take > eret > stall > normal flow.
- Boundaries:
  - Redirect and stall in the same cycle: redirect wins, and the stall request is dropped.
  - Reset mid-count clears the timer immediately.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[31:0], counting cycles with stall=1 and no redirect.
  - Adds outputs exc_cnt[15:0], counting exc_take pulses.
  - Both are wrap-around counters cleared by reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12.
  - EXC_ENTRY default.
  - FSM state encoding: RUN=0, REFILL=1.
- Sub-module md_busy_timer holds the load/decrement counter and md_busy.
- Everything else stays in pipe_ctrl.

Test Plan:
- mult in E (md_startE=1, md_is_divE=0), then mfhi in D for cycles 1–6:
  - md_busy is high for 5 cycles.
  - stallF=stallD=flushE=1 for 6 cycles, counting the issue cycle; the stall releases on cycle 7.
- validM=1, exc_codeM=12, bdM=1, pcM=0x3010:
  - exc_take=1, exc_code_out=12, epc_out=0x300C.
  - redirect_pc=0x4180; flushD/E/M=1.
- int_req=1 with validM=1 immediately after an eret redirect:
  - No take for 3 cycles; exc_take=1 with code 0 on the 4th cycle.
- eretM=1 with exc_codeM=4 in the same cycle:
  - Exception wins: redirect_pc=0x4180, exc_code_out=4.
- div starts in E while exc_take=1:
  - The timer does not load, and md_busy stays 0.
- reset driven low mid-div (count=6):
  - md_busy=0 and state=RUN asynchronously, before the next edge.
